// File: rtl/aes_round_engine_if.sv
// Block handshake bus between a plaintext/key source and the AES round engine.
// Bytes are packed with byte 0 in the most significant position of each 128-bit field.
interface aes_round_engine_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryptor computing UNROLL rounds per clock with on-the-fly key expansion.
// Optional macro AES_ROUND_ENGINE_ABORT_EN adds an abort input that drops the block in flight.
module aes_round_engine #(
    parameter int UNROLL = 1
) (
    input  logic clk,
    input  logic rst,
`ifdef AES_ROUND_ENGINE_ABORT_EN
    input  logic abort,
`endif
    aes_round_engine_if.slave bus
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : gBadUnroll
        $error("aes_round_engine: UNROLL must be 1, 2, 5 or 10");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [127:0] data_q, data_d;
    logic [127:0] key_q, key_d;
    logic [127:0] out_q, out_d;

    logic [127:0] rndData;
    logic [127:0] rndKey;
    logic [7:0]   rndRcon;
    logic [3:0]   rndCnt;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254, which maps 0 to 0) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] nextKey(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h000000};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // State is column-major: byte i sits in row i%4, column i/4.
    function automatic logic [127:0] aesRound(input logic [127:0] s, input logic [127:0] k,
                                              input logic last);
        logic [127:0] t;
        logic [127:0] m;
        logic [7:0]   a0, a1, a2, a3;
        for (int i = 0; i < 16; i++) begin
            int src;
            src = (i % 4) + 4 * (((i / 4) + (i % 4)) % 4);
            t[127 - 8*i -: 8] = sbox(s[127 - 8*src -: 8]);
        end
        m = t;
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[127 - 32*c -: 8];
                a1 = t[119 - 32*c -: 8];
                a2 = t[111 - 32*c -: 8];
                a3 = t[103 - 32*c -: 8];
                m[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                       a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                       a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                       xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
            end
        end
        return m ^ k;
    endfunction

    always_comb begin
        rndData = data_q;
        rndKey  = key_q;
        rndRcon = rcon_q;
        rndCnt  = round_q;
        for (int u = 0; u < UNROLL; u++) begin
            rndKey  = nextKey(rndKey, rndRcon);
            rndData = aesRound(rndData, rndKey, rndCnt == 4'd10);
            rndRcon = xtime(rndRcon);
            rndCnt  = rndCnt + 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        data_d  = data_q;
        key_d   = key_q;
        out_d   = out_q;

        bus.in_ready  = (state_q == IDLE) && !rst;
        bus.out_valid = (state_q == DONE) && !rst;
        bus.out_data  = out_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    data_d  = bus.in_data ^ bus.in_key;
                    key_d   = bus.in_key;
                    rcon_d  = 8'h01;
                    round_d = 4'd1;
                    state_d = RUN;
                end
            end
            RUN: begin
                data_d  = rndData;
                key_d   = rndKey;
                rcon_d  = rndRcon;
                round_d = rndCnt;
                // Counter lands on 11 exactly when round 10 has just been applied.
                if (rndCnt == 4'd11) begin
                    out_d   = rndData;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef AES_ROUND_ENGINE_ABORT_EN
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            round_d = round_q;
            rcon_d  = rcon_q;
            data_d  = data_q;
            key_d   = key_q;
            out_d   = out_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            round_q <= 4'd0;
            rcon_q  <= 8'h01;
            data_q  <= '0;
            key_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            data_q  <= data_d;
            key_q   <= key_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_aes_round_engine.sv
// Directed bench for aes_round_engine: four instances (UNROLL 1, 2, 5, 10) driven with FIPS-197 vectors.
// Covers latency, backpressure, reset mid-run, back-to-back and, with AES_ROUND_ENGINE_ABORT_EN, abort.
module tb_aes_round_engine;

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_Z = 128'h0;
    localparam logic [127:0] PT_Z  = 128'h0;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   inValid;
    logic [3:0]   inReady;
    logic [3:0]   outValid;
    logic [3:0]   outReady;
    logic [127:0] inData  [4];
    logic [127:0] inKey   [4];
    logic [127:0] outData [4];
`ifdef AES_ROUND_ENGINE_ABORT_EN
    logic         abort;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gDut
        aes_round_engine_if bus ();

        assign bus.in_valid  = inValid[g];
        assign bus.in_data   = inData[g];
        assign bus.in_key    = inKey[g];
        assign bus.out_ready = outReady[g];
        assign inReady[g]    = bus.in_ready;
        assign outValid[g]   = bus.out_valid;
        assign outData[g]    = bus.out_data;

        aes_round_engine #(
            .UNROLL(g == 0 ? 1 : (g == 1 ? 2 : (g == 2 ? 5 : 10)))
        ) dut (
            .clk  (clk),
            .rst  (rst),
`ifdef AES_ROUND_ENGINE_ABORT_EN
            .abort(abort),
`endif
            .bus  (bus)
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        checkOutput(tag, {127'b0, observed}, {127'b0, expected});
    endtask

    // Offers one block in the current cycle; returns one cycle after the accept edge (cycle 1).
    task automatic applyStimulus(input int idx, input logic [127:0] data, input logic [127:0] key);
        inValid[idx] = 1'b1;
        inData[idx]  = data;
        inKey[idx]   = key;
        checkBit("accept_in_ready", inReady[idx], 1'b1);
        tick();
        inValid[idx] = 1'b0;
    endtask

    task automatic waitValid(input int idx, input int expLat, input string tag);
        int lat;
        lat = 1;
        while (!outValid[idx] && lat < 40) begin
            tick();
            lat++;
        end
        checkOutput(tag, 128'(lat), 128'(expLat));
    endtask

    task automatic countValid(input int idx, input int cycles, input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (outValid[idx]) seen++;
        end
        checkOutput(tag, 128'(seen), 128'd0);
    endtask

    task automatic backToBack(input int idx, input int lat);
        outReady[idx] = 1'b1;
        inValid[idx]  = 1'b1;
        inData[idx]   = PT_A;
        inKey[idx]    = KEY_A;
        checkBit("b2b_first_ready", inReady[idx], 1'b1);
        tick();
        inData[idx] = PT_B;
        inKey[idx]  = KEY_B;
        checkBit("b2b_run_not_ready", inReady[idx], 1'b0);
        waitValid(idx, lat, "b2b_first_latency");
        checkOutput("b2b_first_data", outData[idx], CT_A);
        checkBit("b2b_handshake_not_ready", inReady[idx], 1'b0);
        tick();
        checkBit("b2b_gap_ready", inReady[idx], 1'b1);
        checkBit("b2b_gap_no_valid", outValid[idx], 1'b0);
        tick();
        inValid[idx] = 1'b0;
        checkOutput("b2b_out_data_held", outData[idx], CT_A);
        waitValid(idx, lat, "b2b_second_latency");
        checkOutput("b2b_second_data", outData[idx], CT_B);
        tick();
        checkBit("b2b_done_released", outValid[idx], 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        inValid  = 4'h0;
        outReady = 4'h0;
        for (int i = 0; i < 4; i++) begin
            inData[i] = '0;
            inKey[i]  = '0;
        end
`ifdef AES_ROUND_ENGINE_ABORT_EN
        abort = 1'b0;
`endif
        tick();
        tick();
        checkOutput("reset_in_ready_low", {124'b0, inReady}, 128'h0);
        checkOutput("reset_out_valid_low", {124'b0, outValid}, 128'h0);
        checkOutput("reset_out_data_zero", outData[0], 128'h0);
        rst = 1'b0;
        #1;
        checkOutput("post_reset_in_ready", {124'b0, inReady}, 128'hf);

        // UNROLL=1, FIPS-197 C.1 vector, out_valid in cycle 11
        outReady[0] = 1'b1;
        applyStimulus(0, PT_A, KEY_A);
        checkBit("u1_run_not_ready", inReady[0], 1'b0);
        waitValid(0, 11, "u1_latency");
        checkOutput("u1_data", outData[0], CT_A);
        checkBit("u1_done_not_ready", inReady[0], 1'b0);
        tick();
        checkBit("u1_after_hs_no_valid", outValid[0], 1'b0);
        checkBit("u1_after_hs_ready", inReady[0], 1'b1);
        checkOutput("u1_data_held_idle", outData[0], CT_A);

        // UNROLL=10, FIPS-197 appendix B vector, out_valid in cycle 2
        outReady[3] = 1'b1;
        applyStimulus(3, PT_B, KEY_B);
        waitValid(3, 2, "u10_latency");
        checkOutput("u10_data", outData[3], CT_B);
        tick();

        // Backpressure on the UNROLL=2 instance
        outReady[1] = 1'b0;
        applyStimulus(1, PT_Z, KEY_Z);
        waitValid(1, 6, "bp_latency");
        checkOutput("bp_data", outData[1], CT_Z);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkBit("bp_valid_held", outValid[1], 1'b1);
            checkOutput("bp_data_held", outData[1], CT_Z);
            checkBit("bp_not_ready", inReady[1], 1'b0);
        end
        outReady[1] = 1'b1;
        checkBit("bp_hs_cycle_not_ready", inReady[1], 1'b0);
        tick();
        checkBit("bp_ready_after_hs", inReady[1], 1'b1);
        checkBit("bp_valid_after_hs", outValid[1], 1'b0);

        // Reset pulsed in RUN cycle 4 on the UNROLL=1 instance
        applyStimulus(0, PT_B, KEY_B);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        checkBit("rst_run_ready_low", inReady[0], 1'b0);
        checkBit("rst_run_valid_low", outValid[0], 1'b0);
        rst = 1'b0;
        #1;
        checkBit("rst_run_ready_after", inReady[0], 1'b1);
        checkOutput("rst_run_data_cleared", outData[0], 128'h0);
        countValid(0, 15, "rst_run_no_valid");
        applyStimulus(0, PT_Z, KEY_Z);
        waitValid(0, 11, "rst_next_latency");
        checkOutput("rst_next_data", outData[0], CT_Z);
        tick();

        // Back-to-back with in_valid held high
        backToBack(1, 6);
        backToBack(2, 3);

`ifdef AES_ROUND_ENGINE_ABORT_EN
        // Abort in RUN cycle 3 on the UNROLL=1 instance
        outReady[0] = 1'b1;
        applyStimulus(0, PT_A, KEY_A);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkBit("abort_idle_ready", inReady[0], 1'b1);
        checkBit("abort_no_valid", outValid[0], 1'b0);
        checkOutput("abort_out_data_kept", outData[0], CT_Z);
        countValid(0, 15, "abort_no_valid_after");
        applyStimulus(0, PT_B, KEY_B);
        waitValid(0, 11, "abort_next_latency");
        checkOutput("abort_next_data", outData[0], CT_B);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_round_engine.md
AES_ROUND_ENGINE -- requirements
Module: aes_round_engine

Interface
REQ-001 SHALL have parameter UNROLL, default 1: AES rounds computed per clock; legal values 1, 2, 5, 10.
REQ-002 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  plaintext/key offered.
REQ-005 SHALL have port in_ready  output  1  engine accepts a block this cycle.
REQ-006 SHALL have port in_data  input  128  plaintext, byte 0 in bits [127:120].
REQ-007 SHALL have port in_key  input  128  AES-128 cipher key, same byte order.
REQ-008 SHALL have port out_valid  output  1  ciphertext available.
REQ-009 SHALL have port out_ready  input  1  consumer takes ciphertext.
REQ-010 SHALL have port out_data  output  128  ciphertext, same byte order.

Function
REQ-011 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-012 SHALL drive in_ready high only in IDLE, and out_valid high only in DONE.
REQ-013 SHALL, on in_valid && in_ready, load state = in_data ^ in_key, round key = in_key, rcon = 8'h01 and round counter = 1, then enter RUN.
REQ-014 SHALL, on each RUN cycle, apply UNROLL consecutive rounds with on-the-fly key expansion; rcon sequence is 01,02,04,08,10,20,40,80,1B,36.
REQ-015 SHALL make rounds 1-9 SubBytes, ShiftRows, MixColumns, AddRoundKey; round 10 SHALL omit MixColumns.
REQ-016 SHALL advance the round counter by UNROLL per RUN cycle, and enter DONE after the cycle that completes round 10.
REQ-017 SHALL give a latency, with the accept cycle as cycle 0, where out_valid first rises in cycle 10/UNROLL + 1 (UNROLL=1: cycle 11; UNROLL=10: cycle 2).
REQ-018 SHALL hold out_valid and out_data stable in DONE until out_ready is high, then return to IDLE on that edge.
REQ-019 SHALL keep in_ready low in the DONE cycle that completes the handshake; no same-cycle bypass, so the next accept is no earlier than the following cycle.
REQ-020 SHALL ignore in_valid, in_data and in_key outside IDLE; inputs need only be stable in the accept cycle.
REQ-021 SHALL hold out_data at the last ciphertext outside DONE; it is not cleared.
REQ-022 SHALL reject illegal UNROLL at elaboration, e.g. via a generate-time error.

Reset
REQ-023 SHALL, with rst high at a clock edge, set the FSM to IDLE, round counter to 0, rcon to 8'h01, and all data and key registers to 0.
REQ-024 SHALL hold out_valid=0 and in_ready=0 while rst is high, with in_ready=1 in the first cycle after rst is deasserted.
REQ-025 SHALL, on rst asserted in RUN or DONE, discard the block in progress; no out_valid follows.

Configuration
REQ-026 SHALL support macro AES_ROUND_ENGINE_ABORT_EN.
REQ-027 SHALL, when AES_ROUND_ENGINE_ABORT_EN is defined, add port abort (input, 1 bit); abort high in RUN or DONE returns the engine to IDLE on that edge, out_valid stays 0, and data registers are left unchanged.
REQ-028 SHALL give abort in IDLE no effect, and SHALL give abort priority over an out_ready handshake in the same cycle; rst overrides abort.
REQ-029 SHALL, when AES_ROUND_ENGINE_ABORT_EN is undefined, have no abort port and no abort logic.

Verification
REQ-030 SHALL cover, UNROLL=1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, with out_valid rising in cycle 11.
REQ-031 SHALL cover, UNROLL=10: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32, with out_valid rising in cycle 2.
REQ-032 SHALL cover backpressure: out_ready held low 5 cycles -> out_valid and out_data stable throughout, and in_ready stays 0 until the cycle after the handshake.
REQ-033 SHALL cover reset mid-run: rst pulsed in RUN cycle 4 (UNROLL=1) -> no out_valid, in_ready=1 the cycle after rst falls, and the next block encrypts correctly.
REQ-034 SHALL cover back-to-back: two blocks with in_valid held high, UNROLL=2 and 5 -> correct ciphertexts in order, with one idle cycle between the handshake and the next accept.
REQ-035 SHALL cover, with AES_ROUND_ENGINE_ABORT_EN defined: abort in RUN cycle 3 -> IDLE the next cycle, no out_valid, and the next block is correct.
